trap_ctrl_u: RTL and testbench
==============================

// Module: trap_ctrl_u
// PURPOSE
//  Sequential machine-mode trap controller; supersedes the combinational exception mux.
//  Prioritises synchronous exceptions and a maskable external interrupt for the instruction in ID.
//  Owns mepc/mcause/mtval/mtvec/mstatus.{MIE,MPIE} and handles MRET.
//  Drives a registered PC redirect plus a multi-cycle pipeline flush.
// PARAMETERS
//  XLEN         32            data/address width
//  MTVEC_RESET  32'h0001_0000 mtvec value after reset; the default trap handler address
//  FLUSH_CYCLES 2             cycles flush is held, counting the redirect cycle; legal range 1..15
//  VECTORED_EN  1             1: honour mtvec[1:0]==2'b01 vectored mode for interrupts; 0: always direct
// PORTS
//  clk               in   1     clock
//  rst               in   1     synchronous, active-high reset
//  inst_valid        in   1     ID holds a real instruction (not a bubble)
//  pc_in_id          in   XLEN  PC of the instruction in ID
//  i_addr_misaligned in   1     fetch misalignment forwarded from IF
//  illegal_instr     in   1     decoder flagged an illegal instruction
//  is_ebreak         in   1     instruction is EBREAK
//  is_ecall          in   1     instruction is ECALL
//  is_mret           in   1     instruction is MRET
//  jump              in   1     older branch/jump taken; the ID instruction is squashed
//  ext_irq           in   1     level-sensitive external interrupt request
//  csr_we            in   1     CSR write strobe
//  csr_waddr         in   12    0x300 mstatus, 0x305 mtvec, 0x341 mepc; other addresses ignored
//  csr_wdata         in   XLEN  CSR write data
//  redirect          out  1     one-cycle pulse: fetch must restart at redirect_pc
//  redirect_pc       out  XLEN  trap target or mepc; 0 when redirect=0
//  flush             out  1     kill IF/ID/EX contents
//  busy              out  1     controller is not IDLE; further events are ignored
//  mepc, mcause, mtval, mtvec  out  XLEN  architectural CSR values
//  mstatus_mie, mstatus_mpie   out  1     interrupt enable and previous enable
// BEHAVIOUR
//  Reset:
//   - state=IDLE; redirect=0, redirect_pc=0, flush=0, busy=0.
//   - mepc=0, mcause=0, mtval=0, mtvec=MTVEC_RESET, MIE=0, MPIE=0.
//   - Reset wins over every other event, including reset in mid-flush.
//  Event qualification (IDLE only): ev = inst_valid & ~jump.
//   - Bubbles and squashed instructions never trap.
//  Priority when ev=1, highest first:
//   - ext_irq & MIE -> mcause 32'h8000_000B
//   - i_addr_misaligned -> mcause 0, mtval=pc_in_id
//   - illegal_instr -> mcause 2, mtval 0
//   - is_ebreak -> mcause 3, mtval=pc_in_id
//   - is_ecall -> mcause 11, mtval 0
//   - is_mret -> return (not a trap)
//  Trap entry, clock edge ending detection cycle T:
//   - mepc<=pc_in_id; mcause and mtval per the priority list.
//   - MPIE<=MIE, MIE<=0.
//   - state<=REDIR; target is latched.
//  Target:
//   - Base = {mtvec[XLEN-1:2], 2'b00}.
//   - Vectored interrupt (VECTORED_EN & mtvec[1:0]==1): base + 4*11.
//   - All other cases: base.
//  MRET, same edge:
//   - MIE<=MPIE, MPIE<=1.
//   - Target = mepc, using its value before any same-cycle CSR write.
//   - state<=REDIR.
//  REDIR (cycle T+1):
//   - redirect=1, redirect_pc=target, flush=1, busy=1.
//   - If FLUSH_CYCLES==1, next state is IDLE; otherwise FLUSH with cnt=FLUSH_CYCLES-2.
//  FLUSH:
//   - flush=1, busy=1, redirect=0.
//   - cnt decrements each cycle; go to IDLE after the cycle in which cnt==0.
//   - Total flush high is FLUSH_CYCLES cycles.
//  Events arriving while busy=1 are dropped; the pipeline is being flushed anyway.
//  CSR writes:
//   - Take effect on the next edge; mepc write clears bit [1:0]; mstatus write updates bits 3 (MIE) and 7 (MPIE).
//   - A write to mtvec, mepc or mstatus on the same edge as trap entry or MRET: the trap/MRET update wins for mepc/mstatus; mtvec writes always land.
//  ext_irq with MIE=0 is ignored.
// TESTING
//  1. ECALL, pc 0x100, mtvec reset:
//     T+1 redirect=1 redirect_pc=0x0001_0000; mepc=0x100, mcause=11, mtval=0; flush high 2 cycles.
//  2. i_addr_misaligned & is_ecall at pc 0x102:
//     mcause=0, mtval=0x102; jump=1 at the same time -> no trap, busy stays 0.
//  3. MIE=1, mtvec=0x2001, ext_irq at pc 0x200:
//     redirect_pc=0x202C, mcause=0x8000_000B, MIE=0, MPIE=1.
//  4. MRET after test 3:
//     redirect_pc=0x200, MIE=1, MPIE=1; an ECALL during FLUSH is ignored.
//  5. rst asserted during the FLUSH cycle:
//     next cycle state IDLE, flush=0, all CSRs at reset values.
//  6. ECALL with csr_we to mepc=0x400 on the same cycle: mepc=pc_in_id, not 0x400.

Source files
------------

// File: rtl/trap_ctrl_u.sv
// Machine-mode trap controller: prioritises exceptions and the external interrupt in ID,
// owns the M-mode trap CSRs, handles MRET, and drives a registered redirect plus a multi-cycle flush.
module trap_ctrl_u #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] MTVEC_RESET  = 32'h0001_0000,
   parameter int              FLUSH_CYCLES = 2,
   parameter bit              VECTORED_EN  = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inst_valid,
   input  logic [XLEN-1:0] pc_in_id,
   input  logic            i_addr_misaligned,
   input  logic            illegal_instr,
   input  logic            is_ebreak,
   input  logic            is_ecall,
   input  logic            is_mret,
   input  logic            jump,
   input  logic            ext_irq,
   input  logic            csr_we,
   input  logic [11:0]     csr_waddr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic            busy,
   output logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] mcause,
   output logic [XLEN-1:0] mtval,
   output logic [XLEN-1:0] mtvec,
   output logic            mstatus_mie,
   output logic            mstatus_mpie
);

   typedef enum logic [1:0] {IDLE, REDIR, FLUSH} state_e;

   localparam logic [XLEN-1:0] CAUSE_IRQ   = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
   localparam logic [XLEN-1:0] CAUSE_MISAL = XLEN'(0);
   localparam logic [XLEN-1:0] CAUSE_ILL   = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_BRK   = XLEN'(3);
   localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);
   localparam logic [XLEN-1:0] VEC_OFFSET  = XLEN'(4 * 11);
   localparam logic [3:0]      CNT_INIT    = (FLUSH_CYCLES >= 2) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            redirect_q, redirect_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            flush_q, flush_d;
   logic            busy_q, busy_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic [XLEN-1:0] mcause_q, mcause_d;
   logic [XLEN-1:0] mtval_q, mtval_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic            mie_q, mie_d;
   logic            mpie_q, mpie_d;

   logic            ev, irq_take, exc_any, trap_take, mret_take;
   logic [XLEN-1:0] tvec_base;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      redirect_d    = redirect_q;
      redirect_pc_d = redirect_pc_q;
      flush_d       = flush_q;
      busy_d        = busy_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      mtvec_d       = mtvec_q;
      mie_d         = mie_q;
      mpie_d        = mpie_q;

      ev        = inst_valid & ~jump;
      irq_take  = ext_irq & mie_q;
      exc_any   = irq_take | i_addr_misaligned | illegal_instr | is_ebreak | is_ecall;
      trap_take = (state_q == IDLE) & ev & exc_any;
      mret_take = (state_q == IDLE) & ev & ~exc_any & is_mret;
      tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

      // CSR writes first so that trap entry / MRET below override mepc and mstatus
      if (csr_we) begin
         case (csr_waddr)
            12'h300: begin
               mie_d  = csr_wdata[3];
               mpie_d = csr_wdata[7];
            end
            12'h305: mtvec_d = csr_wdata;
            12'h341: mepc_d  = {csr_wdata[XLEN-1:2], 2'b00};
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (trap_take) begin
               mepc_d = pc_in_id;
               mpie_d = mie_q;
               mie_d  = 1'b0;
               if (irq_take) begin
                  mcause_d = CAUSE_IRQ;
                  mtval_d  = '0;
               end else if (i_addr_misaligned) begin
                  mcause_d = CAUSE_MISAL;
                  mtval_d  = pc_in_id;
               end else if (illegal_instr) begin
                  mcause_d = CAUSE_ILL;
                  mtval_d  = '0;
               end else if (is_ebreak) begin
                  mcause_d = CAUSE_BRK;
                  mtval_d  = pc_in_id;
               end else begin
                  mcause_d = CAUSE_ECALL;
                  mtval_d  = '0;
               end
               if (VECTORED_EN && irq_take && (mtvec_q[1:0] == 2'b01))
                  redirect_pc_d = tvec_base + VEC_OFFSET;
               else
                  redirect_pc_d = tvec_base;
               redirect_d = 1'b1;
               flush_d    = 1'b1;
               busy_d     = 1'b1;
               state_d    = REDIR;
            end else if (mret_take) begin
               mie_d         = mpie_q;
               mpie_d        = 1'b1;
               redirect_pc_d = mepc_q;
               redirect_d    = 1'b1;
               flush_d       = 1'b1;
               busy_d        = 1'b1;
               state_d       = REDIR;
            end
         end
         REDIR: begin
            redirect_d    = 1'b0;
            redirect_pc_d = '0;
            if (FLUSH_CYCLES == 1) begin
               flush_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (cnt_q == 4'd0) begin
               flush_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            redirect_d    = 1'b0;
            redirect_pc_d = '0;
            flush_d       = 1'b0;
            busy_d        = 1'b0;
            state_d       = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         flush_q       <= 1'b0;
         busy_q        <= 1'b0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mtval_q       <= '0;
         mtvec_q       <= MTVEC_RESET;
         mie_q         <= 1'b0;
         mpie_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         flush_q       <= flush_d;
         busy_q        <= busy_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         mtvec_q       <= mtvec_d;
         mie_q         <= mie_d;
         mpie_q        <= mpie_d;
      end
   end

   assign redirect     = redirect_q;
   assign redirect_pc  = redirect_pc_q;
   assign flush        = flush_q;
   assign busy         = busy_q;
   assign mepc         = mepc_q;
   assign mcause       = mcause_q;
   assign mtval        = mtval_q;
   assign mtvec        = mtvec_q;
   assign mstatus_mie  = mie_q;
   assign mstatus_mpie = mpie_q;

endmodule

// File: tb/tb_trap_ctrl_u.sv
// Directed and randomized bench for trap_ctrl_u, checked against a countdown-based reference model.
module tb_trap_ctrl_u;

   localparam int          FC    = 2;
   localparam logic [31:0] MTVR  = 32'h0001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_valid;
   logic [31:0] pc_in_id;
   logic        i_addr_misaligned, illegal_instr, is_ebreak, is_ecall, is_mret, jump, ext_irq;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [31:0] csr_wdata;
   logic        redirect, flush, busy, mstatus_mie, mstatus_mpie;
   logic [31:0] redirect_pc, mepc, mcause, mtval, mtvec;

   trap_ctrl_u #(.XLEN(32), .MTVEC_RESET(MTVR), .FLUSH_CYCLES(FC), .VECTORED_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .inst_valid(inst_valid), .pc_in_id(pc_in_id),
      .i_addr_misaligned(i_addr_misaligned), .illegal_instr(illegal_instr),
      .is_ebreak(is_ebreak), .is_ecall(is_ecall), .is_mret(is_mret), .jump(jump),
      .ext_irq(ext_irq), .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .busy(busy),
      .mepc(mepc), .mcause(mcause), .mtval(mtval), .mtvec(mtvec),
      .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: architectural CSRs plus a count of remaining busy cycles
   logic [31:0] m_mepc, m_mcause, m_mtval, m_mtvec, e_rpc;
   logic        m_mie, m_mpie, e_redirect;
   int          m_left;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      inst_valid = 0; pc_in_id = 0; i_addr_misaligned = 0; illegal_instr = 0;
      is_ebreak = 0; is_ecall = 0; is_mret = 0; jump = 0; ext_irq = 0;
      csr_we = 0; csr_waddr = 0; csr_wdata = 0;
   endtask

   task automatic model_edge();
      logic [31:0] n_mepc, n_mtvec, base;
      logic        n_mie, n_mpie, ev, irq;
      if (rst) begin
         m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mtvec = MTVR;
         m_mie = 0; m_mpie = 0; m_left = 0; e_redirect = 0; e_rpc = 0;
         return;
      end
      n_mepc = m_mepc; n_mtvec = m_mtvec; n_mie = m_mie; n_mpie = m_mpie;
      if (csr_we && csr_waddr == 12'h300) begin n_mie = csr_wdata[3]; n_mpie = csr_wdata[7]; end
      if (csr_we && csr_waddr == 12'h305) n_mtvec = csr_wdata;
      if (csr_we && csr_waddr == 12'h341) n_mepc = csr_wdata & 32'hFFFF_FFFC;
      ev  = inst_valid && !jump;
      irq = ext_irq && m_mie;
      e_redirect = 0;
      e_rpc      = 0;
      if (m_left > 0) begin
         m_left--;
      end else if (ev && (irq || i_addr_misaligned || illegal_instr || is_ebreak || is_ecall)) begin
         n_mepc = pc_in_id;
         n_mpie = m_mie;
         n_mie  = 0;
         if (irq)                    begin m_mcause = 32'h8000_000B; m_mtval = 0;        end
         else if (i_addr_misaligned) begin m_mcause = 0;             m_mtval = pc_in_id; end
         else if (illegal_instr)     begin m_mcause = 2;             m_mtval = 0;        end
         else if (is_ebreak)         begin m_mcause = 3;             m_mtval = pc_in_id; end
         else                        begin m_mcause = 11;            m_mtval = 0;        end
         base  = m_mtvec & 32'hFFFF_FFFC;
         e_rpc = (irq && m_mtvec[1:0] == 2'b01) ? base + 44 : base;
         e_redirect = 1;
         m_left     = FC;
      end else if (ev && is_mret) begin
         n_mie      = m_mpie;
         n_mpie     = 1;
         e_rpc      = m_mepc;
         e_redirect = 1;
         m_left     = FC;
      end
      m_mepc = n_mepc; m_mtvec = n_mtvec; m_mie = n_mie; m_mpie = n_mpie;
   endtask

   task automatic check_all();
      chk("redirect",    {31'b0, redirect},     {31'b0, e_redirect});
      chk("redirect_pc", redirect_pc,           e_rpc);
      chk("flush",       {31'b0, flush},        {31'b0, m_left > 0});
      chk("busy",        {31'b0, busy},         {31'b0, m_left > 0});
      chk("mepc",        mepc,                  m_mepc);
      chk("mcause",      mcause,                m_mcause);
      chk("mtval",       mtval,                 m_mtval);
      chk("mtvec",       mtvec,                 m_mtvec);
      chk("mie",         {31'b0, mstatus_mie},  {31'b0, m_mie});
      chk("mpie",        {31'b0, mstatus_mpie}, {31'b0, m_mpie});
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      tick(); tick();
      chk("rst_mtvec", mtvec, 32'h0001_0000);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      rst = 0;
      tick();

      // 1: ECALL at 0x100, default mtvec
      inst_valid = 1; pc_in_id = 32'h100; is_ecall = 1;
      tick();
      chk("t1_rpc", redirect_pc, 32'h0001_0000);
      chk("t1_mcause", mcause, 32'd11);
      chk("t1_mepc", mepc, 32'h100);
      idle_inputs();
      tick();
      chk("t1_flush2", {31'b0, flush}, 32'd1);
      tick();
      chk("t1_flush_done", {31'b0, flush}, 32'd0);

      // 2: misaligned beats ecall; then the same with jump squashing it
      inst_valid = 1; pc_in_id = 32'h102; i_addr_misaligned = 1; is_ecall = 1;
      tick();
      chk("t2_mcause", mcause, 32'd0);
      chk("t2_mtval", mtval, 32'h102);
      idle_inputs(); tick(); tick();
      inst_valid = 1; pc_in_id = 32'h102; i_addr_misaligned = 1; is_ecall = 1; jump = 1;
      tick();
      chk("t2_jump_busy", {31'b0, busy}, 32'd0);
      idle_inputs();

      // 3: vectored interrupt
      csr_we = 1; csr_waddr = 12'h300; csr_wdata = 32'h8;
      tick();
      csr_waddr = 12'h305; csr_wdata = 32'h2001;
      tick();
      idle_inputs();
      inst_valid = 1; pc_in_id = 32'h200; ext_irq = 1; is_ecall = 1;
      tick();
      chk("t3_rpc", redirect_pc, 32'h202C);
      chk("t3_mcause", mcause, 32'h8000_000B);
      chk("t3_mie", {31'b0, mstatus_mie}, 32'd0);
      chk("t3_mpie", {31'b0, mstatus_mpie}, 32'd1);
      idle_inputs(); tick(); tick();

      // 4: MRET, then an ECALL during FLUSH is dropped
      inst_valid = 1; pc_in_id = 32'h250; is_mret = 1;
      tick();
      chk("t4_rpc", redirect_pc, 32'h200);
      chk("t4_mie", {31'b0, mstatus_mie}, 32'd1);
      idle_inputs();
      inst_valid = 1; pc_in_id = 32'h300; is_ecall = 1;
      tick();
      chk("t4_ignored", mcause, 32'h8000_000B);
      idle_inputs(); tick();

      // 5: reset in the middle of the flush
      inst_valid = 1; pc_in_id = 32'h180; is_ecall = 1;
      tick();
      idle_inputs(); tick();
      rst = 1;
      tick();
      chk("t5_flush", {31'b0, flush}, 32'd0);
      chk("t5_mepc", mepc, 32'd0);
      chk("t5_mtvec", mtvec, 32'h0001_0000);
      rst = 0;

      // 6: trap entry overrides a same-cycle mepc write
      inst_valid = 1; pc_in_id = 32'h500; is_ecall = 1;
      csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h400;
      tick();
      chk("t6_mepc", mepc, 32'h500);
      idle_inputs(); tick(); tick();

      // mepc write drops the low bits; MRET returns there
      csr_we = 1; csr_waddr = 12'h341; csr_wdata = 32'h403;
      tick();
      chk("mepc_align", mepc, 32'h400);
      idle_inputs();
      inst_valid = 1; is_mret = 1;
      tick();
      chk("mret_rpc", redirect_pc, 32'h400);
      idle_inputs(); tick(); tick();

      // Randomized traffic against the model
      for (int i = 0; i < 2000; i++) begin
         rst               = ($urandom_range(99, 0) < 2);
         inst_valid        = ($urandom_range(99, 0) < 70);
         jump              = ($urandom_range(99, 0) < 15);
         pc_in_id          = $urandom;
         i_addr_misaligned = ($urandom_range(99, 0) < 8);
         illegal_instr     = ($urandom_range(99, 0) < 8);
         is_ebreak         = ($urandom_range(99, 0) < 8);
         is_ecall          = ($urandom_range(99, 0) < 8);
         is_mret           = ($urandom_range(99, 0) < 15);
         ext_irq           = ($urandom_range(99, 0) < 20);
         csr_we            = ($urandom_range(99, 0) < 20);
         case ($urandom_range(3, 0))
            0:       csr_waddr = 12'h300;
            1:       csr_waddr = 12'h305;
            2:       csr_waddr = 12'h341;
            default: csr_waddr = 12'($urandom);
         endcase
         csr_wdata = $urandom;
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
